bcd2bin_seq: RTL

Sequential BCD-to-binary converter using reverse double-dabble (shift right, subtract 3). It is the inverse of the display-side binary-to-BCD path. It takes NDIG packed BCD digits, such as a setpoint or threshold entered on the 7-segment/keypad front end, and produces a BIN_W-bit unsigned binary value for comparison against the temperature reading from the SPI sensor path. A start/busy/done handshake lets the consumer latch the result only once it is stable.

---
 rtl/bcd2bin_pkg.sv | 16 +
 rtl/bcd_digit_adj.sv | 13 +
 rtl/bcd2bin_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/bcd2bin_pkg.sv
// Shared constants and state encoding for the sequential BCD-to-binary converter.
package bcd2bin_pkg;

  localparam int DIG_W = 4;
  localparam logic [DIG_W-1:0] ADJ_THRESH = 4'd8;
  localparam logic [DIG_W-1:0] ADJ_SUB    = 4'd3;
  localparam logic [DIG_W-1:0] BCD_MAX    = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ADJUST,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit reverse double-dabble correction (>=8 -> -3) and invalid-digit flag.
module bcd_digit_adj
  import bcd2bin_pkg::*;
(
  input  logic [DIG_W-1:0] digit,
  output logic [DIG_W-1:0] adj,
  output logic             invalid
);

  assign adj     = (digit >= ADJ_THRESH) ? (digit - ADJ_SUB) : digit;
  assign invalid = (digit > BCD_MAX);

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter (reverse double-dabble, shift right / subtract 3).
// Define BCD2BIN_FAST_EN to fold the digit correction into the shift cycle.
module bcd2bin_seq
  import bcd2bin_pkg::*;
#(
  parameter int NDIG  = 2,
  parameter int BIN_W = 7
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DIG_W*NDIG-1:0]   bcd_in,
  output logic [BIN_W-1:0]        bin,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  localparam int BCD_W = DIG_W * NDIG;
  localparam int CNT_W = $clog2(BIN_W + 1);

`ifdef BCD2BIN_FAST_EN
  localparam bit FAST_EN = 1'b1;
`else
  localparam bit FAST_EN = 1'b0;
`endif

  state_t           state, state_nx;
  logic [BCD_W-1:0] bsr, bsr_nx;
  logic [BIN_W-1:0] rsr, rsr_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [BIN_W-1:0] bin_q, bin_nx;
  logic             err_q, err_nx;

  logic [BCD_W-1:0] adj_in;
  logic [BCD_W-1:0] adj_out;
  logic [NDIG-1:0]  dig_bad;
  logic             any_bad;

  // One correction cell per digit: checks bcd_in while idle, corrects bsr otherwise.
  assign adj_in  = (state == IDLE) ? bcd_in : (FAST_EN ? (bsr >> 1) : bsr);
  assign any_bad = |dig_bad;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    bcd_digit_adj u_adj (
      .digit   (adj_in[g*DIG_W +: DIG_W]),
      .adj     (adj_out[g*DIG_W +: DIG_W]),
      .invalid (dig_bad[g])
    );
  end

  always_comb begin
    state_nx = state;
    bsr_nx   = bsr;
    rsr_nx   = rsr;
    cnt_nx   = cnt;
    bin_nx   = bin_q;
    err_nx   = err_q;
    case (state)
      IDLE: begin
        if (start) begin
          rsr_nx = '0;
          cnt_nx = '0;
          if (any_bad) begin
            bsr_nx   = '0;
            bin_nx   = '0;
            err_nx   = 1'b1;
            state_nx = DONE;
          end else begin
            bsr_nx   = bcd_in;
            state_nx = SHIFT;
          end
        end
      end
      SHIFT: begin
        rsr_nx = {bsr[0], rsr[BIN_W-1:1]};
        bsr_nx = FAST_EN ? adj_out : (bsr >> 1);
        cnt_nx = cnt + 1'b1;
        // Result is latched on entry to DONE so it is already valid while done is high.
        if (cnt_nx == CNT_W'(BIN_W)) begin
          bin_nx   = rsr_nx;
          err_nx   = |bsr_nx;
          state_nx = DONE;
        end else begin
          state_nx = FAST_EN ? SHIFT : ADJUST;
        end
      end
      ADJUST: begin
        bsr_nx   = adj_out;
        state_nx = SHIFT;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      bsr   <= '0;
      rsr   <= '0;
      cnt   <= '0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nx;
      bsr   <= bsr_nx;
      rsr   <= rsr_nx;
      cnt   <= cnt_nx;
      bin_q <= bin_nx;
      err_q <= err_nx;
    end
  end

  assign bin  = bin_q;
  assign err  = err_q;
  assign done = (state == DONE);
  assign busy = (state != IDLE);

endmodule
